tiny_cpu_core: RTL

//  Parametrised multi-cycle accumulator CPU core, successor to the 6-bit TinyTapeout demo CPU.

---
 rtl/tiny_cpu_pkg.sv | 43 ++++
 rtl/tiny_cpu_regfile.sv | 50 +++++
 rtl/tiny_cpu_core.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : tiny_cpu_pkg
// Brief  : Opcodes, FSM state encoding and instruction field offsets shared
//          by the tiny accumulator CPU core and its register file.
// Rev    : 1.0  initial release
// ============================================================================
package tiny_cpu_pkg;

    // Opcode values held in the low nibble of every instruction word
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SWAP = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_JNZ  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;

    // Field layout: op in [3:0], rd directly above, rs directly above rd
    localparam int OP_LSB = 0;
    localparam int OP_W   = 4;
    localparam int RD_LSB = 4;

    typedef enum logic [2:0] {
        ST_ADDR  = 3'd0,
        ST_INSTR = 3'd1,
        ST_EXEC  = 3'd2,
        ST_OPND  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Ops that consume the following program word as an immediate
    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JNZ) || (op == OP_LDI) || (op == OP_JZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module : tiny_cpu_regfile
// Brief  : NREGS x DW register file, two combinational read ports and two
//          write ports (the second port exists so SWAP commits in one cycle).
// Rev    : 1.0  initial release
// ============================================================================
module tiny_cpu_regfile #(
    parameter int DW    = 8,
    parameter int NREGS = 4,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] rd_addr,
    input  logic [RW-1:0] rs_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] rs_data,
    input  logic          wa_en,
    input  logic [RW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic [DW-1:0] regs [NREGS];

    assign rd_data = regs[rd_addr];
    assign rs_data = regs[rs_addr];

    // Storage: every entry resets to 1; port b wins on an address clash,
    // which only happens for SWAP rd,rd where both ports carry the same value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= DW'(1);
            end
        end else begin
            if (wa_en) begin
                regs[wa_addr] <= wa_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tiny_cpu_core.sv
`default_nettype none
// ============================================================================
// Module : tiny_cpu_core
// Brief  : Multi-cycle accumulator CPU: fetch/execute FSM with wait-state
//          memory handshake, register-file ALU ops, conditional jumps,
//          one-cycle output strobe and sticky HALT.
// Rev    : 1.0  initial release
// ============================================================================
module tiny_cpu_core
    import tiny_cpu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 6,
    parameter int NREGS = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted
);

    localparam int RW = $clog2(NREGS);

    // Instruction word must hold opcode plus two register indices
    if (DW < 4 + 2 * RW) begin : g_dw_check
        $error("tiny_cpu_core: DW must be >= 4 + 2*clog2(NREGS)");
    end

    // Jump targets are taken from the low AW bits of the operand word
    if (AW > DW) begin : g_aw_check
        $error("tiny_cpu_core: AW must not exceed DW");
    end

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;

    logic [3:0]    op;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] rs_idx;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] alu_res;
    logic [AW-1:0] imm_addr;

    logic          wa_en;
    logic [DW-1:0] wa_data;
    logic          wb_en;

    assign op       = instr[OP_LSB +: OP_W];
    assign rd_idx   = instr[RD_LSB +: RW];
    assign rs_idx   = instr[RD_LSB + RW +: RW];
    assign imm_addr = mem_rdata[AW-1:0];

    tiny_cpu_regfile #(
        .DW    (DW),
        .NREGS (NREGS),
        .RW    (RW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_idx),
        .rs_addr (rs_idx),
        .rd_data (rd_val),
        .rs_data (rs_val),
        .wa_en   (wa_en),
        .wa_addr (rd_idx),
        .wa_data (wa_data),
        .wb_en   (wb_en),
        .wb_addr (rs_idx),
        .wb_data (rd_val)
    );

    // ALU: two-operand ops wrap modulo 2^DW, no flags
    always_comb begin
        alu_res = rd_val;
        case (op)
            OP_ADD:  alu_res = rd_val + rs_val;
            OP_SUB:  alu_res = rd_val - rs_val;
            OP_AND:  alu_res = rd_val & rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            default: alu_res = rd_val;
        endcase
    end

    // Register write control: ALU/SWAP commit in EXEC, LDI commits when its operand arrives
    always_comb begin
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        wa_data = alu_res;
        if (state == ST_EXEC) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_XOR: wa_en = 1'b1;
                OP_SWAP: begin
                    wa_en   = 1'b1;
                    wb_en   = 1'b1;
                    wa_data = rs_val;
                end
                OP_NOP, OP_JMP, OP_JNZ, OP_LDI, OP_JZ, OP_OUT, OP_HALT: wa_en = 1'b0;
                default: wa_en = 1'b0;
            endcase
        end else if ((state == ST_OPND) && mem_ready && (op == OP_LDI)) begin
            wa_en   = 1'b1;
            wa_data = mem_rdata;
        end
    end

    // Sequencer: fetch, execute and operand phases with registered memory and output signals
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ADDR;
            pc        <= '0;
            instr     <= '0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_ADDR: begin
                    mem_addr <= pc;
                    pc       <= pc + AW'(1);
                    mem_req  <= 1'b1;
                    state    <= ST_INSTR;
                end
                ST_INSTR: begin
                    if (mem_ready) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (is_imm_op(op)) begin
                        mem_addr <= pc;
                        pc       <= pc + AW'(1);
                        mem_req  <= 1'b1;
                        state    <= ST_OPND;
                    end else begin
                        if (op == OP_OUT) begin
                            out_data  <= rd_val;
                            out_valid <= 1'b1;
                        end
                        state <= ST_ADDR;
                    end
                end
                ST_OPND: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= ST_ADDR;
                        // Not-taken branches leave pc pointing past the operand
                        case (op)
                            OP_JMP: pc <= imm_addr;
                            OP_JNZ: if (rd_val != '0) pc <= imm_addr;
                            OP_JZ:  if (rd_val == '0) pc <= imm_addr;
                            default: pc <= pc;
                        endcase
                    end
                end
                ST_HALT: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    state <= ST_ADDR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
